// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_reader
// Description : Recovers BCD digits from a scanned 7-segment bus once a
//               pattern/select pair has been stable for STABLE_CYC samples.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                clr,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     dig_valid,
    output logic [NDIG-1:0]     err_mask,
    output logic                pat_err,
    output logic                frame_stb
);
    localparam int c_run_w = $clog2(STABLE_CYC + 1);
    localparam logic [c_run_w-1:0] c_run_max = c_run_w'(STABLE_CYC);
    localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_held  = 2'd2;

    logic [6:0]         r_s_seg, r_p_seg;
    logic [NDIG-1:0]    r_s_sel, r_p_sel;
    logic [1:0]         r_state;
    logic [c_run_w-1:0] r_run;
    logic [4*NDIG-1:0]  r_bcd;
    logic [NDIG-1:0]    r_valid, r_err, r_seen;
    logic               r_pat_err, r_frame;

    logic               w_onehot, w_same, w_capture;
    logic [c_run_w-1:0] w_run_next;
    logic [1:0]         w_state_next;
    logic [3:0]         w_val;
    logic               w_legal, w_blank, w_frame;
    logic [4*NDIG-1:0]  w_bcd_next;
    logic [NDIG-1:0]    w_valid_next, w_err_next, w_seen_next;

    // Run tracking: r_p_* holds the sample that preceded the current one.
    always_comb begin
        w_onehot     = $onehot(r_s_sel);
        w_same       = (r_s_seg == r_p_seg) && (r_s_sel == r_p_sel);
        w_run_next   = '0;
        w_state_next = c_st_idle;
        w_capture    = 1'b0;
        if (w_onehot) begin
            if (r_state == c_st_idle || !w_same)
                w_run_next = c_run_one;
            else if (r_run == c_run_max)
                w_run_next = r_run;
            else
                w_run_next = r_run + c_run_one;

            if (r_state == c_st_held && w_same) begin
                w_state_next = c_st_held;
            end else if (w_run_next == c_run_max) begin
                w_state_next = c_st_held;
                w_capture    = 1'b1;
            end else begin
                w_state_next = c_st_count;
            end
        end
    end

    always_comb begin
        w_val   = 4'd0;
        w_legal = 1'b1;
        w_blank = 1'b0;
        case (r_s_seg)
            7'h3F: w_val = 4'd0;
            7'h06: w_val = 4'd1;
            7'h5B: w_val = 4'd2;
            7'h4F: w_val = 4'd3;
            7'h66: w_val = 4'd4;
            7'h6D: w_val = 4'd5;
            7'h7D: w_val = 4'd6;
            7'h07: w_val = 4'd7;
            7'h7F: w_val = 4'd8;
            7'h6F: w_val = 4'd9;
            7'h00: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // clr overrides error/frame bookkeeping but never the captured digit data.
    always_comb begin
        w_bcd_next   = r_bcd;
        w_valid_next = r_valid;
        w_err_next   = r_err;
        w_seen_next  = r_seen;
        w_frame      = 1'b0;
        if (w_capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (r_s_sel[i]) begin
                    if (w_legal) begin
                        w_bcd_next[4*i +: 4] = w_val;
                        w_valid_next[i]      = 1'b1;
                    end else begin
                        w_valid_next[i] = 1'b0;
                        if (!w_blank)
                            w_err_next[i] = 1'b1;
                    end
                end
            end
            w_seen_next = r_seen | r_s_sel;
            if (&w_seen_next) begin
                w_frame     = 1'b1;
                w_seen_next = '0;
            end
        end
        if (clr) begin
            w_err_next  = '0;
            w_seen_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_seg   <= '0;
            r_s_sel   <= '0;
            r_p_seg   <= '0;
            r_p_sel   <= '0;
            r_state   <= c_st_idle;
            r_run     <= '0;
            r_bcd     <= '0;
            r_valid   <= '0;
            r_err     <= '0;
            r_seen    <= '0;
            r_pat_err <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_s_seg   <= seg_in;
            r_s_sel   <= dig_sel;
            r_p_seg   <= r_s_seg;
            r_p_sel   <= r_s_sel;
            r_state   <= w_state_next;
            r_run     <= w_run_next;
            r_bcd     <= w_bcd_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
            r_seen    <= w_seen_next;
            r_pat_err <= |w_err_next;
            r_frame   <= w_frame;
        end
    end

    assign bcd_out   = r_bcd;
    assign dig_valid = r_valid;
    assign err_mask  = r_err;
    assign pat_err   = r_pat_err;
    assign frame_stb = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_reader
// Description : Directed bench for seg7_scan_reader with a trailing-run model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_reader;
    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic [3:0]  dig_valid, err_mask;
    logic        pat_err, frame_stb;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .clr(clr),
        .bcd_out(bcd_out), .dig_valid(dig_valid), .err_mask(err_mask),
        .pat_err(pat_err), .frame_stb(frame_stb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int frames = 0;
    logic saw8 = 1'b0;
    logic chk_on = 1'b0;

    // Model: capture fires when the trailing run of identical one-hot samples
    // is exactly STABLE_CYC long.
    logic [6:0]  m_seg, m_prev_seg;
    logic [3:0]  m_sel, m_prev_sel;
    int          m_len;
    logic [15:0] e_bcd;
    logic [3:0]  e_valid, e_err, e_seen;
    logic        e_pat, e_frame;

    always @(posedge clk) begin
        if (rst) begin
            m_seg = '0; m_sel = '0; m_prev_seg = '0; m_prev_sel = '0; m_len = 0;
            e_bcd = '0; e_valid = '0; e_err = '0; e_seen = '0;
            e_pat = 1'b0; e_frame = 1'b0;
        end else begin
            e_frame = 1'b0;
            if ($countones(m_sel) != 1)
                m_len = 0;
            else if (m_len > 0 && m_seg == m_prev_seg && m_sel == m_prev_sel)
                m_len = m_len + 1;
            else
                m_len = 1;
            if (m_len == STABLE_CYC) begin
                for (int d = 0; d < NDIG; d++) begin
                    if (m_sel[d]) begin
                        int v;
                        v = -1;
                        for (int k = 0; k < 10; k++)
                            if (PATS[k] == m_seg) v = k;
                        if (v >= 0) begin
                            e_bcd[4*d +: 4] = 4'(v);
                            e_valid[d] = 1'b1;
                        end else begin
                            e_valid[d] = 1'b0;
                            if (m_seg != 7'h00) e_err[d] = 1'b1;
                        end
                        e_seen[d] = 1'b1;
                    end
                end
                if (e_seen == 4'hF) begin
                    e_frame = 1'b1;
                    e_seen  = '0;
                end
            end
            if (clr) begin
                e_err  = '0;
                e_seen = '0;
            end
            e_pat = (e_err != 0);
            m_prev_seg = m_seg; m_prev_sel = m_sel;
            m_seg = seg_in;     m_sel = dig_sel;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("bcd_out",   32'(bcd_out),   32'(e_bcd));
            check("dig_valid", 32'(dig_valid), 32'(e_valid));
            check("err_mask",  32'(err_mask),  32'(e_err));
            check("pat_err",   32'(pat_err),   32'(e_pat));
            check("frame_stb", 32'(frame_stb), 32'(e_frame));
            if (frame_stb) frames++;
            if (bcd_out[3:0] == 4'd8) saw8 = 1'b1;
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int f0;

    initial begin
        rst = 1'b1; clr = 1'b0; seg_in = '0; dig_sel = '0;
        for (int i = 0; i < 2; i++) begin
            seg_in  = 7'($urandom);
            dig_sel = 4'($urandom);
            @(posedge clk);
            #2;
            chk_on = 1'b1;
        end
        check("rst_bcd",   32'(bcd_out),   32'h0);
        check("rst_valid", 32'(dig_valid), 32'h0);
        check("rst_err",   32'(err_mask),  32'h0);
        check("rst_frame", 32'(frame_stb), 32'h0);
        rst = 1'b0;

        drive(7'h06, 4'b0001, 6);
        drive(7'h5B, 4'b0010, 6);
        drive(7'h4F, 4'b0100, 6);
        check("frames_before_d3", 32'(frames), 32'd0);
        drive(7'h66, 4'b1000, 6);
        check("scan_bcd",    32'(bcd_out),   32'h4321);
        check("scan_valid",  32'(dig_valid), 32'hF);
        check("scan_frames", 32'(frames),    32'd1);

        saw8 = 1'b0;
        drive(7'h7F, 4'b0001, 3);
        drive(7'h6F, 4'b0001, 6);
        check("glitch_bcd0", 32'(bcd_out[3:0]), 32'd9);
        check("glitch_no8",  32'(saw8),         32'd0);

        drive(7'h49, 4'b0010, 6);
        check("ill_err",    32'(err_mask),     32'h2);
        check("ill_pat",    32'(pat_err),      32'h1);
        check("ill_valid1", 32'(dig_valid[1]), 32'h0);
        check("ill_bcd1",   32'(bcd_out[7:4]), 32'h2);
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        @(posedge clk);
        #2;
        check("clr_err", 32'(err_mask), 32'h0);
        check("clr_pat", 32'(pat_err),  32'h0);

        drive(7'h00, 4'b0100, 6);
        check("blank_valid2", 32'(dig_valid[2]), 32'h0);
        check("blank_pat",    32'(pat_err),      32'h0);
        f0 = frames;
        drive(7'h06, 4'b0001, 6);
        drive(7'h5B, 4'b0010, 6);
        drive(7'h66, 4'b1000, 6);
        check("blank_frame", 32'(frames - f0), 32'd1);

        drive(7'h3F, 4'b0011, 10);
        check("multi_bcd",   32'(bcd_out),   32'h4321);
        check("multi_valid", 32'(dig_valid), 32'hB);
        drive(7'h3F, 4'b0001, 2);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("midrst_bcd",   32'(bcd_out),   32'h0);
        check("midrst_valid", 32'(dig_valid), 32'h0);
        check("midrst_err",   32'(err_mask),  32'h0);
        drive(7'h3F, 4'b0001, 6);
        check("after_rst_valid", 32'(dig_valid), 32'h1);
        check("after_rst_bcd",   32'(bcd_out),   32'h0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
